// File: rtl/dbguart_cmd_seq.sv
// Debug UART command sequencer: turns 'W'/'R' byte commands into bus request messages
// and frames the responses back as bytes. Optional WAIT timeout: DBGUART_SEQ_TIMEOUT_EN.
module dbguart_cmd_seq #(
  parameter  int AWID = 32,
  parameter  int DWID = 32,
  parameter  int TWID = 5,
  parameter  int BWID = 2,
  localparam int WID  = 2 + TWID + BWID + AWID + DWID
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     rxdata,
  input  logic           rx_valid,
  output logic           read_rx,
  output logic [7:0]     txdata,
  input  logic           tx_empty,
  output logic           write_tx,
  output logic [WID-1:0] msg_out,
  input  logic           msg_out_ack,
  input  logic [WID-1:0] msg_in,
  output logic           msg_in_ack
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_TXH  = 3'd5;
  localparam logic [2:0] S_TXD  = 3'd6;

  localparam int AB = AWID / 8;
  localparam int DB = DWID / 8;
  localparam logic [BWID-1:0] BSIZE = BWID'($clog2(DB));
  localparam logic [7:0] LAST_AB = 8'(AB - 1);
  localparam logic [7:0] LAST_DB = 8'(DB - 1);

  logic [2:0]      state_r;
  logic            run_r;
  logic            is_wr_r;
  logic            more_r;
  logic [TWID-1:0] tag_r;
  logic [7:0]      cnt_r;
  logic [AWID-1:0] addr_r;
  logic [DWID-1:0] data_r;
  logic [7:0]      hbyte_r;
  logic [7:0]      txdata_r;
`ifdef DBGUART_SEQ_TIMEOUT_EN
  logic [15:0]     to_cnt_r;
`endif

  logic            rx_take_s;
  logic            push_s;
  logic [7:0]      txd_byte_s;
  logic [7:0]      tx_byte_s;
  logic [1:0]      resp_cmd_s;
  logic [TWID-1:0] resp_tag_s;
  logic            resp_hit_s;

  // Handshake decode shared by the sequencer and the output stage
  always_comb begin
    rx_take_s  = run_r && rx_valid &&
                 ((state_r == S_IDLE) || (state_r == S_ADDR) || (state_r == S_DATA));
    push_s     = tx_empty && ((state_r == S_TXH) || (state_r == S_TXD));
    txd_byte_s = 8'(data_r >> (8 * (DB - 1 - int'(cnt_r))));
    tx_byte_s  = (state_r == S_TXD) ? txd_byte_s : hbyte_r;
    resp_cmd_s = msg_in[WID-1 -: 2];
    resp_tag_s = msg_in[WID-3 -: TWID];
    // tag_r has already advanced past the request now outstanding
    resp_hit_s = (state_r == S_WAIT) && (resp_cmd_s == 2'd3) &&
                 (resp_tag_s == (tag_r - TWID'(1)));
  end

  // Port drive: handshakes follow the current state, txdata holds the last pushed byte
  always_comb begin
    read_rx    = rx_take_s;
    write_tx   = push_s;
    txdata     = push_s ? tx_byte_s : txdata_r;
    msg_in_ack = run_r && (resp_cmd_s != 2'd0);
    if (state_r == S_SEND) begin
      msg_out = {(is_wr_r ? 2'd1 : 2'd2), tag_r, BSIZE, addr_r, data_r};
    end else begin
      msg_out = '0;
    end
  end

  // Command sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      run_r    <= 1'b0;
      is_wr_r  <= 1'b0;
      more_r   <= 1'b0;
      tag_r    <= '0;
      cnt_r    <= 8'd0;
      addr_r   <= '0;
      data_r   <= '0;
      hbyte_r  <= 8'h00;
      txdata_r <= 8'h00;
`ifdef DBGUART_SEQ_TIMEOUT_EN
      to_cnt_r <= 16'd0;
`endif
    end else begin
      run_r <= 1'b1;
      if (push_s) begin
        txdata_r <= tx_byte_s;
      end
      case (state_r)
        S_IDLE: if (rx_take_s) begin
          cnt_r  <= 8'd0;
          more_r <= 1'b0;
          if (rxdata == 8'h57 || rxdata == 8'h52) begin
            is_wr_r <= (rxdata == 8'h57);
            state_r <= S_ADDR;
          end else begin
            hbyte_r <= 8'h3F;
            state_r <= S_TXH;
          end
        end
        S_ADDR: if (rx_take_s) begin
          addr_r <= AWID'({addr_r, rxdata});
          if (cnt_r == LAST_AB) begin
            cnt_r <= 8'd0;
            if (is_wr_r) begin
              state_r <= S_DATA;
            end else begin
              data_r  <= '0;
              state_r <= S_SEND;
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        S_DATA: if (rx_take_s) begin
          data_r <= DWID'({data_r, rxdata});
          if (cnt_r == LAST_DB) begin
            cnt_r   <= 8'd0;
            state_r <= S_SEND;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        S_SEND: if (msg_out_ack) begin
          tag_r <= tag_r + TWID'(1);
`ifdef DBGUART_SEQ_TIMEOUT_EN
          to_cnt_r <= 16'd0;
`endif
          if (is_wr_r) begin
            hbyte_r <= 8'h4B;
            state_r <= S_TXH;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (resp_hit_s) begin
            data_r  <= msg_in[DWID-1:0];
            hbyte_r <= 8'h44;
            more_r  <= 1'b1;
            state_r <= S_TXH;
          end else begin
`ifdef DBGUART_SEQ_TIMEOUT_EN
            if (to_cnt_r == 16'hFFFF) begin
              hbyte_r <= 8'h54;
              state_r <= S_TXH;
            end else begin
              to_cnt_r <= to_cnt_r + 16'd1;
            end
`endif
          end
        end
        S_TXH: if (push_s) begin
          cnt_r   <= 8'd0;
          state_r <= more_r ? S_TXD : S_IDLE;
        end
        S_TXD: if (push_s) begin
          if (cnt_r == LAST_DB) begin
            cnt_r   <= 8'd0;
            more_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbguart_cmd_seq.sv
// Directed, table-driven bench for dbguart_cmd_seq at default parameters.
module tb_dbguart_cmd_seq;

  localparam int WID = 73;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     rxdata;
  logic           rx_valid;
  logic           read_rx;
  logic [7:0]     txdata;
  logic           tx_empty;
  logic           write_tx;
  logic [WID-1:0] msg_out;
  logic           msg_out_ack;
  logic [WID-1:0] msg_in;
  logic           msg_in_ack;

  int checks = 0;
  int errors = 0;
  logic [4:0] tag_model = 5'd0;
  logic [7:0] txq[$];

  typedef struct {
    logic [71:0] rxb;   // command bytes, left-justified
    int          nrx;
    int          dly;   // cycles msg_out is held before ack
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic        resp;
    logic [31:0] rdata;
    logic [39:0] txb;   // expected pushed bytes, left-justified
    int          ntx;
  } vec_t;

  vec_t vt[6];

  dbguart_cmd_seq dut (
    .clk(clk), .rst_n(rst_n), .rxdata(rxdata), .rx_valid(rx_valid), .read_rx(read_rx),
    .txdata(txdata), .tx_empty(tx_empty), .write_tx(write_tx), .msg_out(msg_out),
    .msg_out_ack(msg_out_ack), .msg_in(msg_in), .msg_in_ack(msg_in_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_tx) txq.push_back(txdata);
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    int n = 0;
    rxdata = b;
    rx_valid = 1'b1;
    #1;
    while (!read_rx && n < 50) begin
      step();
      n++;
    end
    chk("rx_pop_timeout", 80'(n >= 50), 80'd0);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_msg();
    int n = 0;
    while (msg_out == '0 && n < 20) begin
      step();
      n++;
    end
    chk("msg_timeout", 80'(n >= 20), 80'd0);
  endtask

  task automatic do_ack();
    msg_out_ack = 1'b1;
    step();
    msg_out_ack = 1'b0;
    tag_model = tag_model + 5'd1;
    #1;
    chk("msg_zero_after_ack", 80'(msg_out), 80'd0);
  endtask

  task automatic wait_tx(input int ntx, input logic [39:0] txb);
    int n = 0;
    while (txq.size() < ntx && n < 200) begin
      step();
      n++;
    end
    repeat (4) step();
    chk("tx_count", 80'(txq.size()), 80'(ntx));
    for (int i = 0; i < ntx && i < txq.size(); i++) chk("tx_byte", 80'(txq[i]), 80'(txb[39-8*i -: 8]));
    txq.delete();
  endtask

  task automatic rst_checks();
    chk("rst_read_rx", 80'(read_rx), 80'd0);
    chk("rst_write_tx", 80'(write_tx), 80'd0);
    chk("rst_msg_in_ack", 80'(msg_in_ack), 80'd0);
    chk("rst_msg_out", 80'(msg_out), 80'd0);
    chk("rst_txdata", 80'(txdata), 80'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [WID-1:0] m;
    for (int i = 0; i < v.nrx; i++) put_byte(v.rxb[71-8*i -: 8]);
    if (v.cmd != 2'd0) begin
      wait_msg();
      chk("msg_cmd", 80'(msg_out[72:71]), 80'(v.cmd));
      chk("msg_tag", 80'(msg_out[70:66]), 80'(tag_model));
      chk("msg_bsize", 80'(msg_out[65:64]), 80'd2);
      chk("msg_addr", 80'(msg_out[63:32]), 80'(v.addr));
      chk("msg_data", 80'(msg_out[31:0]), 80'(v.data));
      m = msg_out;
      for (int i = 0; i < v.dly; i++) begin
        step();
        chk("msg_hold", 80'(msg_out), 80'(m));
      end
      do_ack();
      if (v.resp) begin
        msg_in = {2'd3, tag_model - 5'd1, 2'd2, 32'd0, v.rdata};
        #1;
        chk("resp_ack", 80'(msg_in_ack), 80'd1);
        step();
        msg_in = '0;
      end
    end
    wait_tx(v.ntx, v.txb);
  endtask

  initial begin
    vt[0] = '{72'h57_00_00_10_04_DE_AD_BE_EF, 9, 3, 2'd1, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 32'd0, 40'h4B_00000000, 1};
    vt[1] = '{{40'h52_00_00_00_08, 32'd0}, 5, 0, 2'd2, 32'h0000_0008, 32'd0, 1'b1, 32'h1234_5678, 40'h44_12_34_56_78, 5};
    vt[2] = '{{8'h41, 64'd0}, 1, 0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0, 40'h3F_00000000, 1};
    vt[3] = '{72'h57_80_00_00_FC_01_02_03_04, 9, 1, 2'd1, 32'h8000_00FC, 32'h0102_0304, 1'b0, 32'd0, 40'h4B_00000000, 1};
    vt[4] = '{{40'h52_FF_FF_FF_FF, 32'd0}, 5, 2, 2'd2, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'hA55A_00FF, 40'h44_A5_5A_00_FF, 5};
    vt[5] = '{{8'h77, 64'd0}, 1, 0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0, 40'h3F_00000000, 1};

    rst_n = 1'b0; rxdata = 8'h57; rx_valid = 1'b1; tx_empty = 1'b1;
    msg_out_ack = 1'b0; msg_in = {2'd3, 71'd0};
    repeat (3) step();
    rst_checks();
    rx_valid = 1'b0; msg_in = '0;
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 6; k++) run_vec(vt[k]);

    // Wrong-tag response is dropped, rx is left unread in WAIT, then a stalled 'D' frame
    put_byte(8'h52); put_byte(8'h00); put_byte(8'h00); put_byte(8'h00); put_byte(8'h20);
    wait_msg();
    chk("seq_read_tag", 80'(msg_out[70:66]), 80'(tag_model));
    do_ack();
    msg_in = {2'd3, tag_model, 2'd2, 32'd0, 32'h1111_1111};
    #1;
    chk("stale_resp_ack", 80'(msg_in_ack), 80'd1);
    step();
    msg_in = '0;
    rxdata = 8'h57; rx_valid = 1'b1;
    #1;
    chk("no_read_in_wait", 80'(read_rx), 80'd0);
    repeat (5) step();
    rx_valid = 1'b0;
    chk("stale_resp_no_tx", 80'(txq.size()), 80'd0);
    msg_in = {2'd3, tag_model - 5'd1, 2'd2, 32'd0, 32'hCAFE_F00D};
    #1;
    chk("good_resp_ack", 80'(msg_in_ack), 80'd1);
    step();
    msg_in = '0;
    step();
    tx_empty = 1'b0;
    repeat (20) step();
    chk("stall_only_header", 80'(txq.size()), 80'd1);
    tx_empty = 1'b1;
    wait_tx(5, 40'h44_CA_FE_F0_0D);

    // Reset after the third address byte abandons the command and clears the tag
    put_byte(8'h57); put_byte(8'h00); put_byte(8'h00); put_byte(8'h10);
    rst_n = 1'b0;
    rx_valid = 1'b1; msg_in = {2'd3, 71'd0};
    #1;
    rst_checks();
    step();
    rx_valid = 1'b0; msg_in = '0;
    rst_n = 1'b1;
    tag_model = 5'd0;
    repeat (5) step();
    chk("post_rst_no_tx", 80'(txq.size()), 80'd0);
    chk("post_rst_no_msg", 80'(msg_out), 80'd0);
    run_vec(vt[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
